// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU (req0) and LSU (req1) writeback paths.
// Registers the granted write one cycle and tracks outstanding writers per register.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module regfile_wb_arbiter #(
    parameter int WIDTH      = `WORD_WIDTH,
    parameter int REG_COUNT  = 32,
    parameter int ZERO_REG   = 1,
    parameter int CNT_WIDTH  = 16,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [WIDTH-1:0]      rf_data,
    output logic [REG_COUNT-1:0]  pending,
    output logic [CNT_WIDTH-1:0]  stall_cnt0,
    output logic [CNT_WIDTH-1:0]  stall_cnt1
);

    logic                  last_grant;
    logic                  conflict;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WIDTH-1:0]      win_data;
    logic                  win_is_zero;
    logic                  issue_sets;
    logic [REG_COUNT-1:0]  pending_nxt;

    // Round-robin only on conflict; ready is held low while in reset.
    assign conflict   = req0_valid & req1_valid;
    assign req0_ready = rst_n & req0_valid & (~req1_valid | last_grant);
    assign req1_ready = rst_n & req1_valid & (~req0_valid | ~last_grant);
    assign xfer       = req0_ready | req1_ready;
    assign win_addr   = req1_ready ? req1_addr : req0_addr;
    assign win_data   = req1_ready ? req1_data : req0_data;

    assign win_is_zero = (ZERO_REG != 0) && (win_addr == '0);
    assign issue_sets  = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

    // Clear first, then set, so a newer producer issued at the retiring edge stays pending.
    always_comb begin
        pending_nxt = pending;
        if (rf_we)
            pending_nxt[rf_addr] = 1'b0;
        if (issue_sets)
            pending_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            pending    <= '0;
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (conflict)
                last_grant <= req1_ready;
            rf_we <= xfer & ~win_is_zero;
            if (xfer) begin
                rf_addr <= win_addr;
                rf_data <= win_data;
            end
            pending <= pending_nxt;
            if (req0_valid && !req0_ready && stall_cnt0 != '1)
                stall_cnt0 <= stall_cnt0 + 1'b1;
            if (req1_valid && !req1_ready && stall_cnt1 != '1)
                stall_cnt1 <= stall_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; a second instance (ZERO_REG=0, 2-bit counters)
// shares the stimulus to exercise register 0 as a normal register and counter saturation.
module tb_regfile_wb_arbiter;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, issue_valid;
    logic [AW-1:0] req0_addr, req1_addr, issue_addr;
    logic [W-1:0]  req0_data, req1_data;

    logic          req0_ready, req1_ready, rf_we;
    logic [AW-1:0] rf_addr;
    logic [W-1:0]  rf_data;
    logic [31:0]   pending;
    logic [15:0]   stall_cnt0, stall_cnt1;

    logic          b_req0_ready, b_req1_ready, b_rf_we;
    logic [AW-1:0] b_rf_addr;
    logic [W-1:0]  b_rf_data;
    logic [31:0]   b_pending;
    logic [1:0]    b_stall_cnt0, b_stall_cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.WIDTH(W), .REG_COUNT(32), .ZERO_REG(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .pending(pending),
        .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
    );

    regfile_wb_arbiter #(.WIDTH(W), .REG_COUNT(32), .ZERO_REG(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rf_we(b_rf_we), .rf_addr(b_rf_addr), .rf_data(b_rf_data), .pending(b_pending),
        .stall_cnt0(b_stall_cnt0), .stall_cnt1(b_stall_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; issue_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; issue_addr = '0;
        req0_data = '0; req1_data = '0;

        // Reset: readies forced low even with valid asserted
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_stall0", stall_cnt0, 0);
        chk("rst_stall1", stall_cnt1, 0);

        // Single ALU write, addr 5
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_addr", rf_addr, 5);
        chk("t1_rf_data", rf_data, 32'hDEADBEEF);
        tick();
        chk("t1_rf_we_off", rf_we, 0);
        chk("t1_rf_addr_hold", rf_addr, 5);

        // Continuous conflict for 4 cycles: grants 0,1,0,1
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("t2_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            chk("t2_rf_we", rf_we, 1);
            chk("t2_rf_addr", rf_addr, (i % 2 == 0) ? 1 : 2);
            chk("t2_rf_data", rf_data, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_stall0", stall_cnt0, 2);
        chk("t2_stall1", stall_cnt1, 2);

        // Issue to 7, LSU writes 7 three cycles later
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("t3_pend_set", pending[7], 1);
        tick();
        tick();
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        chk("t3_pend_before", pending[7], 1);
        tick();
        req1_valid = 1'b0;
        chk("t3_rf_we", rf_we, 1);
        chk("t3_pend_during", pending[7], 1);
        tick();
        chk("t3_pend_clr", pending[7], 0);
        chk("t3_pend_all", pending, 0);

        // Re-issue to 9 at the edge that retires an older write to 9
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        tick();
        req0_valid = 1'b0;
        chk("t4_rf_addr", rf_addr, 9);
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("t4_pend_set_wins", pending, 32'h0000_0200);
        // Clear of 9 and set of 10 at the same edge
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9A;
        tick();
        req0_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 5'd10;
        tick();
        issue_valid = 1'b0;
        chk("t4_pend_both", pending, 32'h0000_0400);

        // Write and issue to register 0
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h55;
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        chk("t5_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0; issue_valid = 1'b0;
        chk("t5_rf_we", rf_we, 0);
        chk("t5_pend", pending, 32'h0000_0400);
        chk("t5b_rf_we", b_rf_we, 1);
        chk("t5b_rf_addr", b_rf_addr, 0);
        chk("t5b_pend0", b_pending[0], 1);
        tick();
        chk("t5_rf_we_idle", rf_we, 0);
        chk("t5b_pend0_clr", b_pending[0], 0);

        // 7 conflict cycles: req0 stalls 3, req1 stalls 4, last_grant ends at 0
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        repeat (7) tick();
        chk("t6_stall0", stall_cnt0, 5);
        chk("t6_stall1", stall_cnt1, 6);
        chk("t6b_sat0", b_stall_cnt0, 3);
        chk("t6b_sat1", b_stall_cnt1, 3);
        #1;
        chk("t6_ready1_next", req1_ready, 1);

        // Reset mid-transfer
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready0", req0_ready, 0);
        chk("t6_rst_ready1", req1_ready, 0);
        tick();
        chk("t6_rst_rf_we", rf_we, 0);
        chk("t6_rst_rf_addr", rf_addr, 0);
        chk("t6_rst_rf_data", rf_data, 0);
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_stall0", stall_cnt0, 0);
        chk("t6_rst_stall1", stall_cnt1, 0);
        rst_n = 1'b1;
        #1;
        chk("t6_post_ready0", req0_ready, 1);
        chk("t6_post_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t6_post_rf_addr", rf_addr, 3);
        chk("t6_post_stall1", stall_cnt1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (addr_d/we_d/d) between two writeback sources: requester 0 is the ALU pipe and requester 1 is the load/store unit.
- Registers the granted write for one cycle, then drives the register file write port.
- Keeps a pending-write scoreboard. The issue stage uses it to stall consumers of registers whose producers have not yet written back.

Parameters:
- WIDTH, `WORD_WIDTH, data word width.
- REG_COUNT, 32, number of architectural registers; localparam ADDR_WIDTH = $clog2(REG_COUNT).
- ZERO_REG, 1, when 1 register 0 is hardwired: writes to it are accepted but never forwarded, and it is never marked pending.
- CNT_WIDTH, 16, width of each stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  ALU writeback valid
- req0_ready  out  1  ALU writeback accepted this cycle
- req0_addr  in  ADDR_WIDTH  ALU destination register
- req0_data  in  WIDTH  ALU result
- req1_valid  in  1  LSU writeback valid
- req1_ready  out  1  LSU writeback accepted this cycle
- req1_addr  in  ADDR_WIDTH  LSU destination register
- req1_data  in  WIDTH  LSU load data
- issue_valid  in  1  issue stage dispatches an instruction with a destination
- issue_addr  in  ADDR_WIDTH  destination of the dispatched instruction
- rf_we  out  1  to regfile we_d
- rf_addr  out  ADDR_WIDTH  to regfile addr_d
- rf_data  out  WIDTH  to regfile d
- pending  out  REG_COUNT  bit i=1: register i has an outstanding writer
- stall_cnt0  out  CNT_WIDTH  cycles with req0_valid & !req0_ready, saturating
- stall_cnt1  out  CNT_WIDTH  same for req1

Behaviour:
- Reset: all state is cleared at the rising edge with rst_n=0. After that edge:
  - rf_we=0, rf_addr=0, rf_data=0
  - pending=0, stall_cnt0=stall_cnt1=0
  - last_grant=1, so req0 wins the first conflict
  - Writes in flight are dropped.
  - While rst_n=0, req0_ready and req1_ready are forced to 0.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - readyN = grantN. Ready may depend on the valids; valid must not depend on ready.
  - last_grant updates only on a cycle with a conflict, taking the winner's index. Uncontested grants leave it unchanged.
- Handshake: a transfer occurs when validN & readyN. A requester holding valid must hold addr/data stable until ready.
- Output stage, latency 1:
  - A transfer in cycle N produces rf_we=1, rf_addr, rf_data in cycle N+1.
  - The regfile updates at the end of cycle N+1.
  - With no transfer, rf_we=0 next cycle; rf_addr/rf_data hold their last values.
  - Throughput is one write per cycle with no bubbles.
- Zero register: with ZERO_REG=1 and a transfer to address 0, the transfer completes (ready=1) but rf_we=0 next cycle.
- Scoreboard:
  - issue_valid sets pending[issue_addr] at the clock edge, skipped for address 0 when ZERO_REG=1.
  - pending[rf_addr] clears at the same edge where rf_we=1, so the pending bit drops exactly when the regfile holds the new value.
  - Set and clear of the same address at the same edge: set wins, since a newer producer is in flight.
  - Set of one address and clear of a different address at the same edge: both take effect.
  - Issue to an already-pending address: the bit stays 1.
- Stall counters: increment each cycle validN & !readyN, saturating at all-ones with no wrap. They are cleared only by reset.
- Both requesters writing the same address back-to-back: both writes reach the regfile in grant order, and the last one wins.

Test Plan:
- Reset, then req0 only, addr 5, data 0xDEADBEEF, one cycle → req0_ready=1 that cycle; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; following cycle rf_we=0.
- Both valid continuously for 4 cycles, addrs 1/2, reset state → grant order 0,1,0,1; req1 stalls in cycles 1 and 3; stall_cnt0=2, stall_cnt1=2.
- issue_valid addr 7, then req1 write addr 7 three cycles later → pending[7]=1 from the edge after issue until the edge ending the rf_we cycle, then 0.
- issue_valid addr 9 in the same cycle rf_we=1, rf_addr=9 → pending[9] remains 1.
- req0 write to addr 0 with ZERO_REG=1 → req0_ready=1, rf_we stays 0; issue to addr 0 leaves pending=0.
- Hold req1_valid with req0 always winning via forced conflicts, then assert rst_n=0 mid-transfer → all outputs and pending are 0 after the edge; separately, a forced stall_cnt at 0xFFFF stays 0xFFFF.
